pipe_hazard_ctrl: RTL and testbench

// - Parametrised hazard/forwarding controller for the 5-stage RISC-V pipeline (F/D/E/M/W).
// - Generates E-stage forwarding selects, F/D/E/M stall enables and D/E flushes.
// - Adds what the fixed hazard logic lacks:
//   - configurable load-use latency;
//   - data-memory wait handshake with timeout error;
//   - optional stall/flush counters.

---
 rtl/pipe_hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline hazard/forwarding controller; optional HAZ_PERF_CNT_EN perf counters
module pipe_hazard_ctrl #(
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1,
    parameter int MEM_TO   = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rs1_d,
    input  logic [AW-1:0]    rs2_d,
    input  logic [AW-1:0]    rs1_e,
    input  logic [AW-1:0]    rs2_e,
    input  logic [AW-1:0]    rd_e,
    input  logic             load_e,
    input  logic             pcsrc_e,
    input  logic [AW-1:0]    rd_m,
    input  logic             regwrite_m,
    input  logic             mem_req_m,
    input  logic             mem_ready_m,
    input  logic [AW-1:0]    rd_w,
    input  logic             regwrite_w,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             mem_err,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int LCW = 3;
    localparam int WCW = (MEM_TO < 2) ? 1 : $clog2(MEM_TO + 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LSTALL = 2'd1,
        ST_MWAIT  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [LCW-1:0] lcnt_q, lcnt_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           mem_err_q, mem_err_d;

    logic luse, mwait, frozen;
    logic sf, sd, se, sm, fd, fe;

    assign luse   = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    assign mwait  = mem_req_m && !mem_ready_m;
    // A timed-out memory never releases the pipeline; only reset recovers it.
    assign frozen = mwait || mem_err_q;

    always_comb begin
        fwd_a_e = 2'b00;
        fwd_b_e = 2'b00;
        if (rst && (rs1_e != '0)) begin
            if (regwrite_m && (rd_m == rs1_e))      fwd_a_e = 2'b10;
            else if (regwrite_w && (rd_w == rs1_e)) fwd_a_e = 2'b01;
        end
        if (rst && (rs2_e != '0)) begin
            if (regwrite_m && (rd_m == rs2_e))      fwd_b_e = 2'b10;
            else if (regwrite_w && (rd_w == rs2_e)) fwd_b_e = 2'b01;
        end
    end

    always_comb begin
        state_d = state_q;
        lcnt_d  = lcnt_q;
        sf = 1'b0; sd = 1'b0; se = 1'b0; sm = 1'b0; fd = 1'b0; fe = 1'b0;
        case (state_q)
            ST_LSTALL: begin
                if (frozen) begin
                    sf = 1'b1; sd = 1'b1; se = 1'b1; sm = 1'b1;
                end else begin
                    sf = 1'b1; sd = 1'b1; fe = 1'b1;
                    lcnt_d = LCW'(lcnt_q - 3'd1);
                    if (lcnt_q <= 3'd1) state_d = ST_RUN;
                end
            end
            default: begin
                // MWAIT on its release cycle behaves exactly like RUN so deferred events are seen.
                if (frozen) begin
                    sf = 1'b1; sd = 1'b1; se = 1'b1; sm = 1'b1;
                    state_d = ST_MWAIT;
                end else begin
                    state_d = ST_RUN;
                    if (pcsrc_e) begin
                        fd = 1'b1; fe = 1'b1;
                    end else if (luse) begin
                        sf = 1'b1; sd = 1'b1; fe = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = ST_LSTALL;
                            lcnt_d  = LCW'(LOAD_LAT - 1);
                        end
                    end
                end
            end
        endcase
    end

    always_comb begin
        wcnt_d    = '0;
        mem_err_d = mem_err_q;
        if (mwait) begin
            wcnt_d = (wcnt_q == '1) ? wcnt_q : WCW'(wcnt_q + 1'b1);
            if ((MEM_TO != 0) && ((int'(wcnt_q) + 1) >= MEM_TO)) mem_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_RUN;
            lcnt_q    <= '0;
            wcnt_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lcnt_q    <= lcnt_d;
            wcnt_q    <= wcnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign stall_f = rst & sf;
    assign stall_d = rst & sd;
    assign stall_e = rst & se;
    assign stall_m = rst & sm;
    assign flush_d = rst & fd;
    assign flush_e = rst & fe;
    assign mem_err = mem_err_q;
    assign state_o = state_q;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_f && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_d && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       load_e, pcsrc_e, regwrite_m, mem_req_m, mem_ready_m, regwrite_w;

    logic [1:0]  fwd_a_e, fwd_b_e, state_o;
    logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mem_err;
    logic [31:0] stall_cnt, flush_cnt;

    logic [1:0]  fwd_a_e_1, fwd_b_e_1, state_o_1;
    logic        stall_f_1, stall_d_1, stall_e_1, stall_m_1, flush_d_1, flush_e_1, mem_err_1;
    logic [31:0] stall_cnt_1, flush_cnt_1;

    logic [5:0] ctl;
    assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e};

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.AW(5), .LOAD_LAT(3), .MEM_TO(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .load_e(load_e), .pcsrc_e(pcsrc_e), .rd_m(rd_m), .regwrite_m(regwrite_m),
        .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m), .rd_w(rd_w), .regwrite_w(regwrite_w),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .stall_f(stall_f), .stall_d(stall_d),
        .stall_e(stall_e), .stall_m(stall_m), .flush_d(flush_d), .flush_e(flush_e),
        .mem_err(mem_err), .state_o(state_o), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.AW(5), .LOAD_LAT(1), .MEM_TO(16), .CNT_W(32)) dut1 (
        .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .load_e(load_e), .pcsrc_e(pcsrc_e), .rd_m(rd_m), .regwrite_m(regwrite_m),
        .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m), .rd_w(rd_w), .regwrite_w(regwrite_w),
        .fwd_a_e(fwd_a_e_1), .fwd_b_e(fwd_b_e_1), .stall_f(stall_f_1), .stall_d(stall_d_1),
        .stall_e(stall_e_1), .stall_m(stall_m_1), .flush_d(flush_d_1), .flush_e(flush_e_1),
        .mem_err(mem_err_1), .state_o(state_o_1), .stall_cnt(stall_cnt_1), .flush_cnt(flush_cnt_1)
    );

    function automatic logic [1:0] ref_fwd(input int rs, input int rdm, input bit rwm,
                                           input int rdw, input bit rww);
        if (rs == 0) return 2'd0;
        if (rwm && rdm == rs) return 2'd2;
        if (rww && rdw == rs) return 2'd1;
        return 2'd0;
    endfunction

    task automatic idle();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        load_e = 0; pcsrc_e = 0; regwrite_m = 0; mem_req_m = 0; mem_ready_m = 0; regwrite_w = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        rs1_e = 5; rd_m = 5; regwrite_m = 1; mem_req_m = 1; pcsrc_e = 1;
        step(); step();
        @(negedge clk);
        total++; if (ctl !== 6'b0) $display("FAIL reset_ctl got %b want 000000", ctl); else passed++;
        total++; if (fwd_a_e !== 2'b00) $display("FAIL reset_fwd got %b want 00", fwd_a_e); else passed++;
        total++; if (state_o !== 2'd0 || mem_err !== 1'b0) $display("FAIL reset_state got %0d/%b want 0/0", state_o, mem_err); else passed++;
        total++; if (stall_cnt !== 0 || flush_cnt !== 0) $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt); else passed++;
        idle();
        rst = 1'b1;
        step();
    endtask

    task automatic test_forwarding();
        logic [1:0] ea, eb;
        rs1_e = 5; rd_m = 5; regwrite_m = 1; rd_w = 5; regwrite_w = 1;
        @(negedge clk);
        total++; if (fwd_a_e !== 2'b10) $display("FAIL fwd_m_prio got %b want 10", fwd_a_e); else passed++;
        idle();
        rs1_e = 0; rd_m = 0; regwrite_m = 1;
        @(negedge clk);
        total++; if (fwd_a_e !== 2'b00) $display("FAIL fwd_x0 got %b want 00", fwd_a_e); else passed++;
        for (int i = 0; i < 40; i++) begin
            rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
            rd_m = 5'($urandom_range(0, 3)); rd_w = 5'($urandom_range(0, 3));
            regwrite_m = 1'($urandom_range(0, 1)); regwrite_w = 1'($urandom_range(0, 1));
            ea = ref_fwd(rs1_e, rd_m, regwrite_m, rd_w, regwrite_w);
            eb = ref_fwd(rs2_e, rd_m, regwrite_m, rd_w, regwrite_w);
            #2;
            total++; if (fwd_a_e !== ea || fwd_b_e !== eb)
                $display("FAIL fwd_rand got %b/%b want %b/%b", fwd_a_e, fwd_b_e, ea, eb); else passed++;
        end
        idle();
        step();
    endtask

    task automatic test_load_use();
        logic [5:0] ec [4] = '{6'b110001, 6'b110001, 6'b110001, 6'b000000};
        logic [1:0] es [4] = '{2'd0, 2'd1, 2'd1, 2'd0};
        idle();
        load_e = 1; rd_e = 7; rs2_d = 7; rs1_d = 3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (ctl !== ec[i] || state_o !== es[i])
                $display("FAIL load_use_c%0d got %b/%0d want %b/%0d", i, ctl, state_o, ec[i], es[i]); else passed++;
            step();
            idle();
        end
    endtask

    task automatic test_branch_vs_luse();
        idle();
        load_e = 1; rd_e = 9; rs1_d = 9; pcsrc_e = 1;
        @(negedge clk);
        total++; if (ctl !== 6'b000011) $display("FAIL branch_luse got %b want 000011", ctl); else passed++;
        step();
        idle();
        @(negedge clk);
        total++; if (state_o !== 2'd0 || ctl !== 6'b0) $display("FAIL branch_after got %0d/%b want 0/000000", state_o, ctl); else passed++;
        step();
    endtask

    task automatic test_mem_wait();
        idle();
        mem_req_m = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (ctl !== 6'b111100) $display("FAIL mwait_c%0d got %b want 111100", i, ctl); else passed++;
            step();
        end
        mem_ready_m = 1;
        @(negedge clk);
        total++; if (ctl !== 6'b0 || mem_err !== 1'b0) $display("FAIL mwait_ready got %b/%b want 000000/0", ctl, mem_err); else passed++;
        step();
        idle();
        @(negedge clk);
        total++; if (state_o !== 2'd0) $display("FAIL mwait_state got %0d want 0", state_o); else passed++;
        step();
    endtask

    task automatic test_timeout();
        idle();
        mem_req_m = 1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            total++; if (mem_err !== 1'b0) $display("FAIL timeout_early_c%0d got %b want 0", i, mem_err); else passed++;
            step();
        end
        @(negedge clk);
        total++; if (mem_err !== 1'b1) $display("FAIL timeout_set got %b want 1", mem_err); else passed++;
        step();
        idle();
        step();
        @(negedge clk);
        total++; if (mem_err !== 1'b1 || ctl !== 6'b111100) $display("FAIL timeout_sticky got %b/%b want 1/111100", mem_err, ctl); else passed++;
        do_reset();
        @(negedge clk);
        total++; if (mem_err !== 1'b0) $display("FAIL timeout_clear got %b want 0", mem_err); else passed++;
    endtask

    task automatic test_reset_mid_lstall();
        idle();
        load_e = 1; rd_e = 4; rs1_d = 4;
        step();
        idle();
        rs2_e = 6; rd_w = 6; regwrite_w = 1;
        #2;
        total++; if (state_o !== 2'd1) $display("FAIL mid_lstall_enter got %0d want 1", state_o); else passed++;
        rst = 1'b0;
        #1;
        total++; if (ctl !== 6'b0 || fwd_b_e !== 2'b00 || state_o !== 2'd0)
            $display("FAIL mid_lstall_async got %b/%b/%0d want 000000/00/0", ctl, fwd_b_e, state_o); else passed++;
        step();
        rst = 1'b1;
        @(negedge clk);
        total++; if (state_o !== 2'd0 || ctl !== 6'b0) $display("FAIL mid_lstall_release got %0d/%b want 0/000000", state_o, ctl); else passed++;
        step();
        idle();
    endtask

    task automatic test_random_model();
        int bub = 0, waits = 0;
        bit err = 0, mw, lu;
        logic [5:0] ec;
        logic [1:0] ea, eb;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
            rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
            rd_e = 5'($urandom_range(0, 3)); rd_m = 5'($urandom_range(0, 3)); rd_w = 5'($urandom_range(0, 3));
            load_e = ($urandom_range(0, 2) == 0); pcsrc_e = ($urandom_range(0, 6) == 0);
            regwrite_m = 1'($urandom_range(0, 1)); regwrite_w = 1'($urandom_range(0, 1));
            mem_req_m = ($urandom_range(0, 4) == 0); mem_ready_m = 1'($urandom_range(0, 1));
            mw = mem_req_m && !mem_ready_m;
            lu = load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
            if (mw || err)     ec = 6'b111100;
            else if (bub > 0)  begin ec = 6'b110001; bub--; end
            else if (pcsrc_e)  ec = 6'b000011;
            else if (lu)       begin ec = 6'b110001; bub = 2; end
            else               ec = 6'b000000;
            ea = ref_fwd(rs1_e, rd_m, regwrite_m, rd_w, regwrite_w);
            eb = ref_fwd(rs2_e, rd_m, regwrite_m, rd_w, regwrite_w);
            if (mw) begin waits++; if (waits == 16) err = 1; end else waits = 0;
            @(negedge clk);
            total++; if (ctl !== ec || fwd_a_e !== ea || fwd_b_e !== eb)
                $display("FAIL rand_c%0d got %b/%b/%b want %b/%b/%b", n, ctl, fwd_a_e, fwd_b_e, ec, ea, eb); else passed++;
            step();
        end
        idle();
    endtask

    task automatic test_perf_counters();
        int exp_s, exp_f;
`ifdef HAZ_PERF_CNT_EN
        exp_s = 2; exp_f = 1;
`else
        exp_s = 0; exp_f = 0;
`endif
        do_reset();
        load_e = 1; rd_e = 4; rs1_d = 4; step(); idle(); step();
        load_e = 1; rd_e = 8; rs2_d = 8; step(); idle(); step();
        pcsrc_e = 1; step(); idle(); step();
        @(negedge clk);
        total++; if (stall_cnt_1 !== 32'(exp_s) || flush_cnt_1 !== 32'(exp_f))
            $display("FAIL perf_cnt got %0d/%0d want %0d/%0d", stall_cnt_1, flush_cnt_1, exp_s, exp_f); else passed++;
        step();
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_vs_luse();
        test_mem_wait();
        test_timeout();
        test_reset_mid_lstall();
        test_random_model();
        test_perf_counters();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
